// File: rtl/spi_xfer_ctrl_if.sv
// rtl/spi_xfer_ctrl_if.sv - host command/stream and byte-engine signal bundle
// slave is the controller's view; master is the host plus byte engine side.
interface spi_xfer_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             done;
  logic             cs_n;
  logic             spi_start;
  logic [7:0]       spi_data_in;
  logic             spi_busy;
  logic             spi_new_data;
  logic [7:0]       spi_data_out;

  modport slave (
    input  cmd_valid, cmd_len, tx_valid, tx_data, rx_ready,
           spi_busy, spi_new_data, spi_data_out,
    output cmd_ready, tx_ready, rx_valid, rx_data, done, cs_n,
           spi_start, spi_data_in
  );

  modport master (
    output cmd_valid, cmd_len, tx_valid, tx_data, rx_ready,
           spi_busy, spi_new_data, spi_data_out,
    input  cmd_ready, tx_ready, rx_valid, rx_data, done, cs_n,
           spi_start, spi_data_in
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - multi-byte SPI transaction sequencer
// Owns chip select timing and feeds one byte at a time to the byte engine.
module spi_xfer_ctrl #(
  parameter int LEN_W    = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic           clk,
  input  logic           rst,
  spi_xfer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, WAIT_TX, START, WAIT_BYTE, RX_OUT, HOLD, GAP
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             cs_n_q, cs_n_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [7:0]       spi_data_in_q, spi_data_in_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      remaining_q   <= '0;
      cs_n_q        <= 1'b1;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= 8'd0;
      spi_data_in_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      remaining_q   <= remaining_d;
      cs_n_q        <= cs_n_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      spi_data_in_q <= spi_data_in_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    cs_n_d        = cs_n_q;
    rx_valid_d    = rx_valid_q;
    rx_data_d     = rx_data_q;
    spi_data_in_d = spi_data_in_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          remaining_d = bus.cmd_len;
          cs_n_d      = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.tx_valid) begin
          spi_data_in_d = bus.tx_data;
          state_d       = START;
        end
      end
      START: begin
        if (!bus.spi_busy) state_d = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        if (bus.spi_new_data) begin
          rx_data_d  = bus.spi_data_out;
          rx_valid_d = 1'b1;
          state_d    = RX_OUT;
        end
      end
      RX_OUT: begin
        // A host stall only stretches the inter-byte gap; cs_n stays low.
        if (bus.rx_ready) begin
          rx_valid_d = 1'b0;
          if (remaining_q == '0) begin
            state_d = HOLD;
          end else begin
            remaining_d = remaining_q - LEN_W'(1);
            state_d     = WAIT_TX;
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cs_n_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // One shared delay counter, restarted on every state change.
    cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
  end

  always_comb begin
    bus.cmd_ready   = (state_q == IDLE) && !rst;
    bus.tx_ready    = (state_q == WAIT_TX);
    bus.spi_start   = (state_q == START) && !bus.spi_busy;
    bus.done        = (state_q == GAP) && (cnt_q == GAP_LAST);
    bus.cs_n        = cs_n_q;
    bus.rx_valid    = rx_valid_q;
    bus.rx_data     = rx_data_q;
    bus.spi_data_in = spi_data_in_q;
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - directed-vector bench for spi_xfer_ctrl
// The byte engine model answers each byte with byte ^ 8'h99 after a short busy window.
module tb_spi_xfer_ctrl;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_GAP   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_ctrl_if #(.LEN_W(8)) bus ();

  spi_xfer_ctrl #(
    .LEN_W(8), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  logic       eng_busy   = 1'b0;
  logic       eng_new    = 1'b0;
  logic       force_busy = 1'b0;
  logic [7:0] eng_byte   = 8'd0;
  logic [7:0] eng_out    = 8'd0;
  logic [1:0] eng_cnt    = 2'd0;

  assign bus.spi_busy     = eng_busy | force_busy;
  assign bus.spi_new_data = eng_new;
  assign bus.spi_data_out = eng_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_busy <= 1'b0;
      eng_new  <= 1'b0;
      eng_cnt  <= 2'd0;
    end else begin
      eng_new <= 1'b0;
      if (bus.spi_start && !eng_busy) begin
        eng_busy <= 1'b1;
        eng_cnt  <= 2'd3;
        eng_byte <= bus.spi_data_in;
      end else if (eng_busy) begin
        if (eng_cnt == 2'd0) begin
          eng_busy <= 1'b0;
          eng_new  <= 1'b1;
          eng_out  <= eng_byte ^ 8'h99;
        end else begin
          eng_cnt <= eng_cnt - 2'd1;
        end
      end
    end
  end

  int cyc = 0, n_acc = 0, n_start = 0, n_new = 0, n_done = 0, n_txhs = 0, n_rise = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, first_start_cyc = 0, last_new_cyc = 0;
  int done_cyc = 0, acc_cyc = 0;
  logic prev_cs = 1'b1;
  logic [7:0] start_data[$];
  logic [7:0] rx_got[$];
  logic [7:0] tx_q[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.cmd_valid && bus.cmd_ready) begin n_acc++; acc_cyc = cyc; end
    if (bus.tx_valid && bus.tx_ready) n_txhs++;
    if (bus.spi_start) begin
      if (start_data.size() == 0) first_start_cyc = cyc;
      start_data.push_back(bus.spi_data_in);
      n_start++;
    end
    if (bus.spi_new_data) begin n_new++; last_new_cyc = cyc; end
    if (bus.done) begin n_done++; done_cyc = cyc; end
    if (bus.rx_valid && bus.rx_ready) rx_got.push_back(bus.rx_data);
    if (prev_cs && !bus.cs_n) cs_fall_cyc = cyc;
    if (!prev_cs && bus.cs_n) begin cs_rise_cyc = cyc; n_rise++; end
    prev_cs = bus.cs_n;
  end

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'd0;
    forever begin
      @(posedge clk);
      if (bus.tx_valid && bus.tx_ready && tx_q.size() > 0) void'(tx_q.pop_front());
      #1;
      bus.tx_valid = (tx_q.size() > 0);
      bus.tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  task automatic wait_for(input string tag, input int which, input int target);
    int n;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      case (which)
        0:       n = n_acc;
        1:       n = n_start;
        2:       n = n_new;
        3:       n = n_done;
        default: n = n_txhs;
      endcase
      if (n >= target) return;
    end
    chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic clear_logs();
    start_data.delete();
    rx_got.delete();
  endtask

  initial begin
    int s0, d0, r0, a0, h0, n0, ok, lat;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd0;
    bus.rx_ready  = 1'b1;
    tx_q.push_back(8'hA5);

    // reset held with a pending command
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_tx_ready", bus.tx_ready, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_spi_start", bus.spi_start, 0);
    chk("rst_spi_data_in", bus.spi_data_in, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_no_accept", n_acc, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    chk("first_edge_accept", n_acc, 1);
    @(negedge clk);
    chk("accept_cs_low", bus.cs_n, 0);

    // single byte 0xA5 -> 0x3C
    wait_for("t2_done", 3, 1);
    @(posedge clk);
    chk("t2_done_once", n_done, 1);
    chk("t2_start_count", start_data.size(), 1);
    chk("t2_tx_byte", start_data[0], 8'hA5);
    chk("t2_rx_count", rx_got.size(), 1);
    chk("t2_rx_byte", rx_got[0], 8'h3C);
    chk("t2_setup_ge", (first_start_cyc - cs_fall_cyc) >= CS_SETUP, 1);
    chk("t2_hold_ge", (cs_rise_cyc - last_new_cyc) >= CS_HOLD, 1);

    // three bytes; next command queued while busy with a different length
    #1 clear_logs();
    tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03);
    bus.cmd_len = 8'd2; bus.cmd_valid = 1'b1;
    wait_for("t3_accept", 0, 2);
    #1 bus.cmd_len = 8'd1;
    r0 = n_rise;
    wait_for("t3_done", 3, 2);
    chk("t3_start_count", start_data.size(), 3);
    chk("t3_tx0", start_data[0], 8'h01);
    chk("t3_tx1", start_data[1], 8'h02);
    chk("t3_tx2", start_data[2], 8'h03);
    chk("t3_rx_count", rx_got.size(), 3);
    chk("t3_rx0", rx_got[0], 8'h98);
    chk("t3_rx1", rx_got[1], 8'h9B);
    chk("t3_rx2", rx_got[2], 8'h9A);
    chk("t3_cs_single_rise", n_rise - r0, 1);
    chk("t3_cs_rise_after_last", cs_rise_cyc > last_new_cyc, 1);
    lat = done_cyc - last_new_cyc;
    chk("t3_done_latency", (lat >= CS_HOLD + CS_GAP) && (lat <= CS_HOLD + CS_GAP + 2), 1);

    // two bytes with the host stalling rx for 20 cycles
    #1 bus.rx_ready = 1'b0;
    clear_logs();
    tx_q.push_back(8'h55); tx_q.push_back(8'h66);
    wait_for("t4_accept", 0, 3);
    chk("t4_gap_ge", (acc_cyc - cs_rise_cyc) >= CS_GAP, 1);
    #1 bus.cmd_valid = 1'b0;
    n0 = n_new;
    wait_for("t4_first_byte", 2, n0 + 1);
    s0 = n_start;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1 && bus.rx_data === 8'hCC &&
          bus.tx_ready === 1'b0 && bus.cs_n === 1'b0) ok++;
    end
    @(posedge clk);
    chk("t4_stall_stable", ok, 20);
    chk("t4_no_second_start", n_start - s0, 0);
    chk("t4_no_rx_yet", rx_got.size(), 0);
    #1 bus.rx_ready = 1'b1;
    wait_for("t4_done", 3, 3);
    chk("t4_rx_count", rx_got.size(), 2);
    chk("t4_rx0", rx_got[0], 8'hCC);
    chk("t4_rx1", rx_got[1], 8'hFF);
    chk("t4_tx1", start_data[1], 8'h66);

    // byte engine busy when START is reached
    @(posedge clk);
    chk("t4_done_once", n_done, 3);
    #1 clear_logs();
    force_busy = 1'b1;
    tx_q.push_back(8'h5A);
    bus.cmd_len = 8'd0; bus.cmd_valid = 1'b1;
    wait_for("t5_accept", 0, 4);
    #1 bus.cmd_valid = 1'b0;
    h0 = n_txhs;
    wait_for("t5_tx_taken", 4, h0 + 1);
    s0 = n_start;
    repeat (5) @(posedge clk);
    chk("t5_start_deferred", n_start - s0, 0);
    #1 force_busy = 1'b0;
    wait_for("t5_done", 3, 4);
    chk("t5_start_once", start_data.size(), 1);
    chk("t5_tx_byte", start_data[0], 8'h5A);
    chk("t5_rx_byte", rx_got[0], 8'hC3);

    // reset while the second of four bytes is in flight
    @(posedge clk);
    #1 clear_logs();
    d0 = n_done; s0 = n_start; a0 = n_acc;
    tx_q.push_back(8'h10); tx_q.push_back(8'h20); tx_q.push_back(8'h30); tx_q.push_back(8'h40);
    bus.cmd_len = 8'd3; bus.cmd_valid = 1'b1;
    wait_for("t6_accept", 0, a0 + 1);
    #1 bus.cmd_valid = 1'b0;
    wait_for("t6_second_byte", 1, s0 + 2);
    @(negedge clk); #1 rst = 1'b1;
    #1 chk("t6_async_cs_n", bus.cs_n, 1);
    chk("t6_async_tx_ready", bus.tx_ready, 0);
    tx_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_idle_ready", bus.cmd_ready, 1);
    chk("t6_cs_n_high", bus.cs_n, 1);
    repeat (20) @(posedge clk);
    chk("t6_no_done", n_done, d0);

    // fresh single-byte transaction after the abort
    #1 clear_logs();
    a0 = n_acc;
    tx_q.push_back(8'h77);
    bus.cmd_len = 8'd0; bus.cmd_valid = 1'b1;
    wait_for("t7_accept", 0, a0 + 1);
    #1 bus.cmd_valid = 1'b0;
    wait_for("t7_done", 3, d0 + 1);
    chk("t7_tx_byte", start_data[0], 8'h77);
    chk("t7_rx_byte", rx_got[0], 8'hEE);
    @(posedge clk);
    chk("t7_done_once", n_done, d0 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Multi-byte SPI transaction sequencer that sits directly upstream of the byte-level SPI master (start / data_in / busy / new_data / data_out). It accepts a transaction command from a host (FPGA register/command logic), owns chip-select with programmable setup, hold and gap timing, and streams TX bytes into the byte engine one at a time. It returns each received byte on a valid/ready interface. It emits a single done pulse per completed transaction.

Parameters:
LEN_W, 8, width of cmd_len; a transaction carries cmd_len+1 bytes (1..2^LEN_W).
CS_SETUP, 4, clk cycles from cs_n falling to first spi_start; legal range 1..255.
CS_HOLD, 4, clk cycles from last byte's spi_new_data to cs_n rising; legal range 1..255.
CS_GAP, 8, minimum clk cycles cs_n stays high before the next cmd is accepted; legal range 1..255.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  host requests a transaction
cmd_ready  out  1  controller can accept cmd (IDLE only)
cmd_len  in  LEN_W  byte count minus one, sampled on cmd handshake
tx_valid  in  1  tx_data holds next byte to send
tx_ready  out  1  controller accepts tx byte
tx_data  in  8  byte to transmit, MSB first
rx_valid  out  1  rx_data holds a received byte
rx_ready  in  1  host consumes rx byte
rx_data  out  8  received byte
done  out  1  one-cycle pulse at end of transaction
cs_n  out  1  active-low chip select to slave
spi_start  out  1  one-cycle start strobe to byte engine
spi_data_in  out  8  byte to byte engine; stable while spi_start high
spi_busy  in  1  byte engine busy
spi_new_data  in  1  byte engine completion pulse
spi_data_out  in  8  byte engine received byte

Behaviour:
- Reset (async, immediate): state IDLE; cs_n=1, cmd_ready=0 until first clk edge after release, tx_ready=0, rx_valid=0, rx_data=0, spi_start=0, spi_data_in=0, done=0. Reset mid-transaction deasserts cs_n asynchronously; no done is issued.
- States: IDLE, SETUP, WAIT_TX, START, WAIT_BYTE, RX_OUT, HOLD, GAP.
- IDLE: cmd_ready=1. On cmd_valid, latch remaining=cmd_len, clear the delay counter, then go to SETUP. cs_n=0 from the next cycle.
- SETUP: count CS_SETUP cycles, then WAIT_TX.
- WAIT_TX: tx_ready=1. On tx_valid, latch tx_data into spi_data_in, then START.
- START: spi_start=1 for exactly one cycle, gated by spi_busy=0. If spi_busy=1, remain in START with spi_start=0. Then WAIT_BYTE.
- WAIT_BYTE: wait for spi_new_data. On the pulse, rx_data<=spi_data_out, rx_valid<=1, then RX_OUT. spi_start is never asserted here.
- RX_OUT: rx_valid held with rx_data stable until rx_ready. If rx_valid & rx_ready occur on the same cycle, rx_valid drops next cycle.
  - If remaining==0, go to HOLD.
  - Otherwise remaining<=remaining-1, go to WAIT_TX.
  - cs_n stays low throughout; host stalls only stretch the inter-byte gap.
- HOLD: count CS_HOLD cycles from entry, then cs_n<=1 and GAP.
- GAP: count CS_GAP cycles with cs_n=1. On the final cycle, done=1 for one cycle, then IDLE. cmd_ready rises on the cycle after done.
- Per-byte ordering: tx_ready handshake -> spi_start -> spi_new_data -> rx handshake. At most one byte in flight; no TX prefetch.
- cmd_valid outside IDLE is ignored (cmd_ready=0). tx_valid outside WAIT_TX is ignored. spi_new_data outside WAIT_BYTE is ignored.
- Counters: 8-bit delay counter reused across SETUP/HOLD/GAP, cleared on each state entry. remaining is LEN_W wide; cmd_len=2^LEN_W-1 yields 2^LEN_W bytes without wrap.

Test Plan:
- Reset held high, then released with cmd_valid=1 -> cs_n=1, all strobes 0 during reset; cmd accepted on the first clk edge after release.
- cmd_len=0, tx 0xA5, byte engine model echoes 0x3C, rx_ready=1 -> exactly one spi_start with spi_data_in=0xA5; rx_data=0x3C with one rx_valid; cs_n low ≥4 cycles before spi_start and ≥4 after new_data; one done.
- cmd_len=2, tx 0x01,0x02,0x03 -> three spi_start pulses in order, three rx bytes, cs_n continuously low; done fires 4+8 cycles after third new_data; next cmd not accepted before cs_n has been high 8 cycles.
- cmd_len=1, rx_ready held low 20 cycles after first byte -> rx_valid/rx_data stable for 20 cycles, tx_ready=0, no second spi_start, cs_n stays low.
- spi_busy forced high 5 cycles at START -> spi_start deferred until busy=0, asserted exactly once.
- Assert rst during WAIT_BYTE of a 4-byte transfer -> cs_n=1 the same cycle (async), no done, IDLE after release; a fresh cmd_len=0 transaction completes normally.
